// File: rtl/if_fetch.sv
// Instruction-fetch stage with IF/ID register: owns the PC, fetches over a
// req/ready + rvalid handshake and presents one instruction at a time to decode.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        arst,
  input  logic [3:0]  hold_i,
  input  logic        jump_ena_i,
  input  logic [31:0] jump_addr_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  output logic        inst_valid_o
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_IDLE} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] addr_q;
  logic        discard;
  logic        started;
  logic        buf_valid;
  logic [31:0] buf_inst;
  logic [31:0] buf_addr;

  logic [31:0] jump_target;
  logic        accept;
  logic        deliver;
  logic        out_ready;
  logic        unused_bits;

  assign jump_target = {jump_addr_i[31:2], 2'b00};
  assign unused_bits = ^{hold_i[3:2], jump_addr_i[1:0]};

  // The request stays low until the first edge after reset release.
  assign imem_req_o  = (state == S_REQ) && started;
  assign imem_addr_o = pc;

  assign accept    = imem_req_o && imem_ready_i;
  assign deliver   = (state == S_WAIT) && imem_rvalid_i && !discard && !jump_ena_i;
  assign out_ready = !hold_i[1] || !inst_valid_o;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state   <= S_REQ;
      pc      <= RESET_PC;
      addr_q  <= RESET_PC;
      discard <= 1'b0;
      started <= 1'b0;
    end else begin
      started <= 1'b1;
      if (jump_ena_i)
        pc <= jump_target;
      else if (accept)
        pc <= pc + 32'd4;
      case (state)
        S_REQ: begin
          if (accept) begin
            addr_q  <= pc;
            state   <= S_WAIT;
            discard <= jump_ena_i;
          end
        end
        S_WAIT: begin
          if (imem_rvalid_i) begin
            discard <= 1'b0;
            // A delivery that lands in the buffer must park the FSM in IDLE.
            if (discard || jump_ena_i)
              state <= S_REQ;
            else if (!hold_i[0] && out_ready)
              state <= S_REQ;
            else
              state <= S_IDLE;
          end else if (jump_ena_i) begin
            discard <= 1'b1;
          end
        end
        S_IDLE: begin
          if (jump_ena_i || (!hold_i[0] && !buf_valid))
            state <= S_REQ;
        end
        default: state <= S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      inst_o       <= NOP_INST;
      inst_addr_o  <= RESET_PC;
      inst_valid_o <= 1'b0;
      buf_valid    <= 1'b0;
      buf_inst     <= NOP_INST;
      buf_addr     <= RESET_PC;
    end else if (jump_ena_i) begin
      inst_o       <= NOP_INST;
      inst_valid_o <= 1'b0;
      buf_valid    <= 1'b0;
    end else if (buf_valid && !hold_i[1]) begin
      inst_o       <= buf_inst;
      inst_addr_o  <= buf_addr;
      inst_valid_o <= 1'b1;
      buf_valid    <= 1'b0;
    end else if (deliver) begin
      if (out_ready) begin
        inst_o       <= imem_rdata_i;
        inst_addr_o  <= addr_q;
        inst_valid_o <= 1'b1;
      end else begin
        buf_inst  <= imem_rdata_i;
        buf_addr  <= addr_q;
        buf_valid <= 1'b1;
      end
    end else if (!hold_i[1]) begin
      inst_o       <= NOP_INST;
      inst_valid_o <= 1'b0;
    end
  end

endmodule
